// File: rtl/multicycle_core_if.sv
// Instruction- and data-memory request/ack bus shared by multicycle_core and its memories.
interface multicycle_core_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 16
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [PC_W-1:0]   dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT with req/ack memories.
// Define MC_BNE_EN to add BNE (op 0x05); otherwise that opcode halts the core.
module multicycle_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 16,
  parameter int unsigned NREG   = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  multicycle_core_if.master   bus,
  output logic [DATA_W-1:0]   ALUOut,
  output logic [2:0]          State,
  output logic                Halted
);

  localparam int unsigned RegAw = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] rf_q [NREG];

  logic              rf_we;
  logic [RegAw-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [5:0]        op, funct;
  logic [RegAw-1:0]  rs, rt, rd;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] alu_res;
  logic              funct_ok;

  assign op       = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rs       = ir_q[21 +: RegAw];
  assign rt       = ir_q[16 +: RegAw];
  assign rd       = ir_q[11 +: RegAw];
  assign imm_sext = DATA_W'($signed(ir_q[15:0]));

  // Requests are forced low while reset is held so an in-flight access is abandoned.
  assign bus.imem_req   = Reset & (state_q == StFetch);
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = Reset & (state_q == StMem);
  assign bus.dmem_we    = Reset & (state_q == StMem) & (op == OpSw);
  assign bus.dmem_addr  = PC_W'(alu_q);
  assign bus.dmem_wdata = b_q;

  assign ALUOut = alu_q;
  assign State  = state_q;
  assign Halted = (state_q == StHalt);

  always_comb begin
    alu_res  = '0;
    funct_ok = 1'b1;
    case (funct)
      FnAdd:   alu_res = a_q + b_q;
      FnSub:   alu_res = a_q - b_q;
      FnAnd:   alu_res = a_q & b_q;
      FnOr:    alu_res = a_q | b_q;
      FnSlt:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = alu_q;

    case (state_q)
      StFetch: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          pc_d    = pc_q + PC_W'(4);
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        // Branch target is precomputed here so EXEC only has to compare.
        alu_d = DATA_W'(pc_q) + (imm_sext << 2);
        case (op)
          OpJ: begin
            pc_d    = PC_W'({ir_q[25:0], 2'b00});
            state_d = StFetch;
          end
`ifdef MC_BNE_EN
          OpBne,
`endif
          OpRtype, OpAddi, OpLw, OpSw, OpBeq: state_d = StExec;
          default: state_d = StHalt;
        endcase
      end
      StExec: begin
        case (op)
          OpRtype: begin
            if (funct_ok) begin
              alu_d   = alu_res;
              state_d = StWb;
            end else begin
              state_d = StHalt;
            end
          end
          OpAddi: begin
            alu_d   = a_q + imm_sext;
            state_d = StWb;
          end
          OpLw, OpSw: begin
            alu_d   = a_q + imm_sext;
            state_d = StMem;
          end
          OpBeq: begin
            if (a_q == b_q) pc_d = PC_W'(alu_q);
            state_d = StFetch;
          end
`ifdef MC_BNE_EN
          OpBne: begin
            if (a_q != b_q) pc_d = PC_W'(alu_q);
            state_d = StFetch;
          end
`endif
          default: state_d = StHalt;
        endcase
      end
      StMem: begin
        if (bus.dmem_ack) begin
          if (op == OpSw) begin
            state_d = StFetch;
          end else begin
            mdr_d   = bus.dmem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        state_d = StFetch;
        case (op)
          OpAddi: rf_waddr = rt;
          OpLw: begin
            rf_waddr = rt;
            rf_wdata = mdr_q;
          end
          default: rf_waddr = rd;
        endcase
      end
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      // Register 0 is never written, so it always reads back as zero.
      if (rf_we && (rf_waddr != '0)) rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: an ISA-level model predicts fetch/data traffic.
module tb_multicycle_core;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 16;
  localparam int unsigned NREG   = 32;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic [DATA_W-1:0] ALUOut;
  logic [2:0]        State;
  logic              Halted;

  multicycle_core_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  multicycle_core #(.DATA_W(DATA_W), .PC_W(PC_W), .NREG(NREG)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .bus    (bus),
    .ALUOut (ALUOut),
    .State  (State),
    .Halted (Halted)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] alu;
    int          gap;
  } fev_t;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } dev_t;

  logic [31:0] prog [256];
  logic [31:0] mem  [256];
  logic [31:0] mmem [256];
  logic [31:0] mregs [32];
  fev_t fq[$];
  dev_t dq[$];

  int errors = 0;
  int checks = 0;
  int max_wait = 0;
  int fixed_dwait = -1;
  bit zero_wait = 1'b0;

  localparam logic [31:0] HaltInsn = 32'hFC00_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] ej(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  // ISA-level interpreter: walks the program and queues every expected bus transaction.
  task automatic run_model();
    logic [15:0] pc;
    logic [31:0] exp_alu;
    int gap;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    for (int i = 0; i < 256; i++) mmem[i] = mem[i];
    pc = '0;
    exp_alu = '0;
    gap = 0;
    for (int step = 0; step < 600; step++) begin
      fev_t f;
      dev_t d;
      logic [31:0] ir, a, b, sx, res, ba;
      logic [5:0] op, fn;
      int rs, rt, rd;
      bit halt;
      f.addr = pc;
      f.alu = exp_alu;
      f.gap = gap;
      fq.push_back(f);
      ir = prog[pc[9:2]];
      op = ir[31:26];
      fn = ir[5:0];
      rs = int'(ir[25:21]);
      rt = int'(ir[20:16]);
      rd = int'(ir[15:11]);
      a = mregs[rs];
      b = mregs[rt];
      sx = {{16{ir[15]}}, ir[15:0]};
      pc = pc + 16'd4;
      ba = {16'h0, pc} + (sx << 2);
      halt = 1'b0;
      res = '0;
      case (op)
        6'h00: begin
          case (fn)
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: halt = 1'b1;
          endcase
          if (!halt) begin
            if (rd != 0) mregs[rd] = res;
            exp_alu = res;
            gap = 4;
          end
        end
        6'h08: begin
          res = a + sx;
          if (rt != 0) mregs[rt] = res;
          exp_alu = res;
          gap = 4;
        end
        6'h23: begin
          res = a + sx;
          d.we = 1'b0; d.addr = res[15:0]; d.wdata = b;
          dq.push_back(d);
          if (rt != 0) mregs[rt] = mmem[res[9:2]];
          exp_alu = res;
          gap = 5;
        end
        6'h2B: begin
          res = a + sx;
          d.we = 1'b1; d.addr = res[15:0]; d.wdata = b;
          dq.push_back(d);
          mmem[res[9:2]] = b;
          exp_alu = res;
          gap = 4;
        end
        6'h04: begin
          if (a == b) pc = ba[15:0];
          exp_alu = ba;
          gap = 3;
        end
`ifdef MC_BNE_EN
        6'h05: begin
          if (a != b) pc = ba[15:0];
          exp_alu = ba;
          gap = 3;
        end
`endif
        6'h02: begin
          pc = {ir[13:0], 2'b00};
          exp_alu = ba;
          gap = 2;
        end
        default: halt = 1'b1;
      endcase
      if (halt) break;
    end
  endtask

  // Monitor: checks every new request against the scoreboard queues.
  initial begin : monitor
    int cyc, last_f, dheld;
    bit ip, dp;
    logic [15:0] ia;
    logic [63:0] dcap;
    fev_t f;
    dev_t d;
    cyc = 0; last_f = 0; dheld = 0; ip = 0; dp = 0; ia = '0; dcap = '0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Reset) begin
        ip = 0;
        dp = 0;
      end else begin
        if (Halted) chk("halt_no_req", {bus.imem_req, bus.dmem_req}, 0);
        if (bus.imem_req) begin
          if (!ip) begin
            ip = 1;
            ia = bus.imem_addr;
            if (fq.size() == 0) begin
              checks++; errors++;
              $display("FAIL fetch_unexpected: got addr %0h, required no fetch", ia);
            end else begin
              f = fq.pop_front();
              chk("fetch_addr", ia, f.addr);
              chk("aluout_at_fetch", ALUOut, f.alu);
              if (zero_wait && f.gap > 0) chk("latency", cyc - last_f, f.gap);
            end
            last_f = cyc;
          end else begin
            chk("imem_addr_stable", bus.imem_addr, ia);
          end
          if (bus.imem_ack) ip = 0;
        end
        if (bus.dmem_req) begin
          if (!dp) begin
            dp = 1;
            dheld = 0;
            dcap = {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata};
            if (dq.size() == 0) begin
              checks++; errors++;
              $display("FAIL dmem_unexpected: got addr %0h, required no access", bus.dmem_addr);
            end else begin
              d = dq.pop_front();
              chk("dmem_we", bus.dmem_we, d.we);
              chk("dmem_addr", bus.dmem_addr, d.addr);
              if (d.we) chk("dmem_wdata", bus.dmem_wdata, d.wdata);
            end
          end else begin
            chk("dmem_stable", {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, dcap);
          end
          dheld++;
          if (bus.dmem_ack) begin
            dp = 0;
            if (fixed_dwait >= 0) chk("dmem_req_cycles", dheld, fixed_dwait + 1);
          end
        end
      end
    end
  end

  initial begin : imem_resp
    bit act;
    int cnt;
    act = 0; cnt = 0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge Clk);
      #2;
      if (bus.imem_ack) begin
        bus.imem_ack = 1'b0;
      end else if (bus.imem_req) begin
        if (!act) begin
          act = 1;
          cnt = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
        end
        if (cnt == 0) begin
          bus.imem_ack = 1'b1;
          bus.imem_rdata = prog[bus.imem_addr[9:2]];
          act = 0;
        end else begin
          cnt--;
        end
      end else begin
        act = 0;
      end
    end
  end

  initial begin : dmem_resp
    bit act;
    int cnt;
    act = 0; cnt = 0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(posedge Clk);
      #2;
      if (bus.dmem_ack) begin
        bus.dmem_ack = 1'b0;
      end else if (bus.dmem_req) begin
        if (!act) begin
          act = 1;
          if (fixed_dwait >= 0) cnt = fixed_dwait;
          else cnt = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
        end
        if (cnt == 0) begin
          bus.dmem_ack = 1'b1;
          if (bus.dmem_we) mem[bus.dmem_addr[9:2]] = bus.dmem_wdata;
          else bus.dmem_rdata = mem[bus.dmem_addr[9:2]];
          act = 0;
        end else begin
          cnt--;
        end
      end else begin
        act = 0;
      end
    end
  end

  task automatic clear_all();
    for (int i = 0; i < 256; i++) begin
      prog[i] = HaltInsn;
      mem[i] = '0;
    end
  endtask

  task automatic start_prog();
    @(negedge Clk);
    #1 Reset = 1'b0;
    fq.delete();
    dq.delete();
    @(negedge Clk);
    @(negedge Clk);
    chk("reset_state", State, 0);
    chk("reset_halted", Halted, 0);
    chk("reset_aluout", ALUOut, 0);
    chk("reset_reqs", {bus.imem_req, bus.dmem_req, bus.dmem_we}, 0);
    run_model();
    #1 Reset = 1'b1;
  endtask

  task automatic finish_prog();
    int n;
    int bad;
    n = 0;
    while (!Halted && n < 4000) begin
      @(negedge Clk);
      n++;
    end
    chk("halt_reached", Halted, 1);
    repeat (4) @(negedge Clk);
    chk("state_halt", State, 5);
    chk("fetch_q_drained", fq.size(), 0);
    chk("dmem_q_drained", dq.size(), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mmem[i]) bad++;
    chk("mem_vs_model", bad, 0);
  endtask

  task automatic gen_random();
    logic [5:0] fns [5];
    int n;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    clear_all();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    n = 24 + int'($urandom_range(16, 0));
    for (int i = 0; i < n; i++) begin
      logic [4:0] rs, rt, rd;
      logic [15:0] off;
      int k;
      k = int'($urandom_range(7, 0));
      rs = 5'($urandom_range(7, 0));
      rt = 5'($urandom_range(7, 0));
      rd = 5'($urandom_range(7, 0));
      off = 16'($urandom_range(63, 0)) << 2;
      case (k)
        0, 1: prog[i] = ei(6'h08, rs, rt, 16'($urandom));
        2, 3: prog[i] = er(rs, rt, rd, fns[$urandom_range(4, 0)]);
        4: prog[i] = ei(6'h23, 5'd0, rt, off);
        5: prog[i] = ei(6'h2B, 5'd0, rt, off);
        6: prog[i] = ei(6'h04, rs, rt, 16'($urandom_range(2, 0)));
        default: prog[i] = ej(26'(i + 1 + int'($urandom_range(2, 0))));
      endcase
    end
    for (int r = 1; r < 8; r++) prog[n + r - 1] = ei(6'h2B, 5'd0, 5'(r), 16'(32'h200 + 4 * r));
    prog[n + 7] = HaltInsn;
  endtask

  initial begin : main
    int n;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;

    // Arithmetic, register-zero and signed-compare program, zero-wait memories.
    clear_all();
    prog[0]  = ei(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1]  = ei(6'h08, 5'd0, 5'd2, 16'hFFFD);
    prog[2]  = er(5'd1, 5'd2, 5'd3, 6'h20);
    prog[3]  = ei(6'h08, 5'd0, 5'd0, 16'd7);
    prog[4]  = er(5'd0, 5'd0, 5'd5, 6'h20);
    prog[5]  = ei(6'h23, 5'd0, 5'd6, 16'h0100);
    prog[6]  = ei(6'h08, 5'd0, 5'd7, 16'd1);
    prog[7]  = er(5'd6, 5'd7, 5'd4, 6'h2A);
    prog[8]  = ei(6'h2B, 5'd0, 5'd3, 16'h0200);
    prog[9]  = ei(6'h2B, 5'd0, 5'd5, 16'h0204);
    prog[10] = ei(6'h2B, 5'd0, 5'd4, 16'h0208);
    mem[64] = 32'h8000_0000;
    max_wait = 0; fixed_dwait = -1; zero_wait = 1;
    start_prog();
    finish_prog();
    chk("add_result", mem[128], 2);
    chk("r0_discard", mem[129], 0);
    chk("slt_signed", mem[130], 1);

    // BEQ at 0x10 skips to 0x1C, J 0x40 lands at 0x100.
    clear_all();
    prog[0]  = ei(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1]  = ei(6'h08, 5'd0, 5'd2, 16'd1);
    prog[2]  = ei(6'h08, 5'd0, 5'd3, 16'd2);
    prog[3]  = ei(6'h08, 5'd0, 5'd4, 16'd3);
    prog[4]  = ei(6'h04, 5'd1, 5'd1, 16'd2);
    prog[5]  = ei(6'h08, 5'd0, 5'd5, 16'd9);
    prog[6]  = ei(6'h08, 5'd0, 5'd5, 16'd9);
    prog[7]  = ej(26'h40);
    prog[64] = ei(6'h2B, 5'd0, 5'd1, 16'h0200);
    prog[65] = ei(6'h2B, 5'd0, 5'd5, 16'h0204);
    start_prog();
    finish_prog();
    chk("jump_target_store", mem[128], 5);
    chk("beq_skipped", mem[129], 0);

    // Store then load with a 3-cycle data wait.
    clear_all();
    prog[0] = ei(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = ei(6'h2B, 5'd0, 5'd1, 16'd8);
    prog[2] = ei(6'h23, 5'd0, 5'd4, 16'd8);
    prog[3] = ei(6'h2B, 5'd0, 5'd4, 16'd12);
    max_wait = 2; fixed_dwait = 3; zero_wait = 0;
    start_prog();
    finish_prog();
    chk("sw_mem", mem[2], 5);
    chk("lw_r4", mem[3], 5);

    // Opcode 0x05: branch when BNE is built in, halt otherwise.
    clear_all();
    prog[0] = ei(6'h08, 5'd0, 5'd1, 16'd1);
    prog[1] = ei(6'h05, 5'd1, 5'd0, 16'd1);
    prog[2] = ei(6'h08, 5'd0, 5'd2, 16'd9);
    prog[3] = ei(6'h2B, 5'd0, 5'd2, 16'h0210);
    mem[132] = 32'h1234;
    max_wait = 0; fixed_dwait = -1; zero_wait = 1;
    start_prog();
    finish_prog();
`ifdef MC_BNE_EN
    chk("bne_taken", mem[132], 0);
`else
    chk("bne_unknown_halts", mem[132], 32'h1234);
`endif

    // Reset while a store waits for its ack; a stray ack during reset is ignored.
    clear_all();
    prog[0] = ei(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = ei(6'h2B, 5'd0, 5'd1, 16'd8);
    fixed_dwait = 20; zero_wait = 0;
    start_prog();
    n = 0;
    while (!bus.dmem_req && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("sw_req_seen", bus.dmem_req, 1);
    @(negedge Clk);
    #1 Reset = 1'b0;
    bus.dmem_ack = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_mid_state", State, 0);
    chk("rst_mid_pc", bus.imem_addr, 0);
    chk("rst_mid_dreq", bus.dmem_req, 0);
    chk("rst_mid_nowrite", mem[2], 0);
    fixed_dwait = -1;
    start_prog();
    finish_prog();
    chk("rerun_store", mem[2], 5);

    // Random programs; the first runs zero-wait so instruction latencies are checked.
    for (int p = 0; p < 5; p++) begin
      gen_random();
      max_wait = (p == 0) ? 0 : 3;
      zero_wait = (p == 0);
      fixed_dwait = -1;
      start_prog();
      finish_prog();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
